// File: rtl/cam_capture.sv
// OV7670 byte-stream capture: crops each frame to WIDTH x HEIGHT pixels, writes it
// linearly into the frame buffer, and freezes the buffer for the encoder on request.
module cam_capture #(
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 200,
  parameter int unsigned BYTES_PP = 2,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        pdata,
  input  logic              frame_req,
  output logic              frame_lock,
  output logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned LINE_BYTES = WIDTH * BYTES_PP;
  localparam int unsigned COL_W      = $clog2(LINE_BYTES + 1);
  localparam int unsigned ROW_W      = $clog2(HEIGHT + 1);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(LINE_BYTES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_BYTES - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(HEIGHT);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  typedef enum logic [1:0] {SYNC, CAPTURE, HOLD} state_t;

  state_t            state, state_nxt;
  logic              frame_valid, frame_valid_nxt;
  logic              q_vsync, q_vsync_d, q_href, q_href_d;
  logic [7:0]        q_pdata;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic              vs_rise, line_end, wr_go, last_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_vsync   <= 1'b0;
      q_vsync_d <= 1'b0;
      q_href    <= 1'b0;
      q_href_d  <= 1'b0;
      q_pdata   <= '0;
    end else begin
      q_vsync   <= vsync;
      q_vsync_d <= q_vsync;
      q_href    <= href;
      q_href_d  <= q_href;
      q_pdata   <= pdata;
    end
  end

  always_comb begin
    vs_rise   = q_vsync & ~q_vsync_d;
    line_end  = ~q_href & q_href_d;
    wr_go     = (state == CAPTURE) && q_href && (col < COL_MAX) && (row < ROW_MAX) && !q_vsync;
    last_byte = wr_go && (row == ROW_LAST) && (col == COL_LAST);
  end

  // col only advances on an accepted write, so col>0 at line end means the line was kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (q_vsync) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (wr_go) begin
      col <= col + COL_W'(1);
    end else if (line_end && (col != '0)) begin
      col      <= '0;
      row      <= (row < ROW_MAX) ? row + ROW_W'(1) : row;
      row_base <= row_base + LINE_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= wr_go;
      frame_done <= last_byte;
      if (wr_go) begin
        wr_addr <= row_base + ADDR_W'(col);
        wr_data <= q_pdata;
      end
      if (last_byte) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= frame_valid_nxt;
    end
  end

  // a final-byte write in this cycle counts toward the lock decision
  always_comb begin
    state_nxt       = state;
    frame_valid_nxt = frame_valid | last_byte;
    case (state)
      SYNC: begin
        if (vs_rise) begin
          state_nxt       = CAPTURE;
          frame_valid_nxt = 1'b0;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          if (frame_req && frame_valid_nxt) state_nxt = HOLD;
          else                              frame_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (vs_rise && !frame_req) begin
          state_nxt       = CAPTURE;
          frame_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign frame_lock = (state == HOLD);

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: directed scenarios plus random frames, checked against a
// frame-level model that predicts every buffer write and the lock decision per vsync.
module tb_cam_capture;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 2;
  localparam int unsigned BPP = 2;
  localparam int unsigned AW  = 17;
  localparam int unsigned LB  = W * BPP;

  logic          clk = 1'b0;
  logic          reset_n, vsync, href, frame_req;
  logic [7:0]    pdata;
  logic          frame_lock, frame_done, wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, frame_cnt;

  cam_capture #(.WIDTH(W), .HEIGHT(H), .BYTES_PP(BPP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href), .pdata(pdata),
    .frame_req(frame_req), .frame_lock(frame_lock), .frame_done(frame_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned addr;
    logic [7:0]  data;
    bit          done;
    logic [7:0]  cnt;
    int unsigned at;
  } wr_t;

  wr_t         expq[$];
  bit          m_armed, m_locked, m_full;
  int unsigned m_row;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    m_armed = 0; m_locked = 0; m_full = 0; m_row = 0; m_cnt = 8'd0;
    expq.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one href line; keep=1 leaves href high (line cut by a following vsync)
  task automatic drive_line(input int unsigned len, input bit seq, input int unsigned base,
                            input bit keep);
    bit cap;
    wr_t e;
    cap = m_armed && !m_locked;
    for (int unsigned k = 0; k < len; k++) begin
      pdata = seq ? 8'(base + k) : 8'($urandom);
      href  = 1'b1;
      if (cap && m_row < H && k < LB) begin
        e.addr = m_row * LB + k;
        e.data = pdata;
        e.done = (m_row == H - 1) && (k == LB - 1);
        if (e.done) begin
          m_cnt  = m_cnt + 8'd1;
          m_full = 1;
        end
        e.cnt = m_cnt;
        e.at  = cyc + 2;
        expq.push_back(e);
      end
      step();
    end
    if (!keep) begin
      href = 1'b0;
      if (cap && len > 0 && m_row < H) m_row++;
      repeat ($urandom_range(1, 3)) step();
    end
  endtask

  task automatic vsync_pulse();
    bit old_lock;
    old_lock = m_locked;
    m_row = 0;
    if (!m_armed) begin
      m_armed = 1;
      m_full  = 0;
    end else if (m_locked) begin
      if (!frame_req) begin
        m_locked = 0;
        m_full   = 0;
      end
    end else if (frame_req && m_full) begin
      m_locked = 1;
    end else begin
      m_full = 0;
    end
    vsync = 1'b1;
    step();
    href = 1'b0;
    @(negedge clk);
    check("lock_at_vs_rise", frame_lock, old_lock);
    step();
    @(negedge clk);
    check("lock_after_vs_rise", frame_lock, m_locked);
    step();
    vsync = 1'b0;
    repeat (2) step();
  endtask

  task automatic full_frame();
    for (int unsigned l = 0; l < H; l++) drive_line(LB, 0, 0, 0);
  endtask

  // write monitor: every predicted write must appear on its exact cycle, nothing else
  always @(negedge clk) begin
    bit  exp_en;
    wr_t e;
    if (reset_n) begin
      exp_en = (expq.size() > 0) && (expq[0].at == cyc);
      if (exp_en || wr_en || frame_done) begin
        check("wr_en", wr_en, exp_en);
        if (exp_en) begin
          e = expq.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("frame_done", frame_done, e.done);
          check("frame_cnt_wr", frame_cnt, e.cnt);
        end else begin
          check("frame_done_idle", frame_done, 1'b0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 8'd0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_frame_cnt"}, frame_cnt, 8'd0);
    check({tag, "_frame_lock"}, frame_lock, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; vsync = 1'b0; href = 1'b0; pdata = 8'd0; frame_req = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("reset");
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // incrementing pattern, frame 1
    vsync_pulse();
    drive_line(LB, 1, 0, 0);
    drive_line(LB, 1, LB, 0);
    repeat (3) step();
    check("frame_cnt_first", frame_cnt, 8'd1);

    // overlong line, excess line
    vsync_pulse();
    drive_line(LB + 3, 0, 0, 0);
    drive_line(LB, 0, 0, 0);
    drive_line(LB, 0, 0, 0);

    // short line leaves a hole, frame still completes
    vsync_pulse();
    drive_line(5, 0, 0, 0);
    drive_line(LB, 0, 0, 0);
    repeat (3) step();
    check("frame_cnt_short", frame_cnt, m_cnt);

    // lock on a complete frame, release later
    frame_req = 1'b1;
    vsync_pulse();
    full_frame();
    frame_req = 1'b0;
    full_frame();
    vsync_pulse();
    full_frame();

    // request while the frame is incomplete
    vsync_pulse();
    drive_line(LB, 0, 0, 0);
    frame_req = 1'b1;
    vsync_pulse();
    full_frame();
    vsync_pulse();
    frame_req = 1'b0;
    vsync_pulse();

    // vsync arriving mid-line aborts it
    drive_line(LB, 0, 0, 0);
    drive_line(3, 0, 0, 1);
    vsync_pulse();
    full_frame();

    // asynchronous reset while addr 6 is on the bus
    vsync_pulse();
    drive_line(LB, 0, 0, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    href = 1'b0;
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    step();
    full_frame();
    vsync_pulse();
    full_frame();

    // random frames
    for (int f = 0; f < 30; f++) begin
      frame_req = 1'($urandom_range(0, 1));
      vsync_pulse();
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) drive_line($urandom_range(0, LB + 3), 0, 0, 0);
        else                           drive_line(LB, 0, 0, 0);
      end
    end

    repeat (6) step();
    check("queue_drained", expq.size(), 0);
    check("frame_cnt_final", frame_cnt, m_cnt);
    check("frame_lock_final", frame_lock, m_locked);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
